perm_arbiter_ctrl: RTL and testbench
====================================

Name: perm_arbiter_ctrl

Overview:
Sequences the shared 64-bit inverse-permutation engine and arbitrates it between NREQ requesters, such as the ballot-record decode and audit-readback paths. The engine uses a set/status handshake: a set pulse clears it, and status rises once data_out is valid. This block grants one requester at a time, arms the engine, waits for status, then returns the result on a single response channel tagged with the requester ID.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 16, max cycles in RUN waiting for eng_status before aborting with error
IDW, 3, width of requester ID (>= clog2(NREQ))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_data  in  64*NREQ  requester i word at bits [64*i +: 64]
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of requester served
rsp_data  out  64  permuted word
rsp_err  out  1  engine timeout (or check fail, see option)
eng_set  out  1  engine clear strobe
eng_data_in  out  64  word presented to engine
eng_status  in  1  engine done
eng_data_out  in  64  engine result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, eng_set=1 (engine held cleared), eng_data_in=0, busy=0. Round-robin pointer=0. Timeout counter=0.
- FSM states: IDLE, ARM, RUN, RESP.
- IDLE: eng_set=1. If any req_valid is high, the round-robin winner is chosen, starting the search at the pointer.
  - req_ready[winner]=1 combinationally in IDLE only, so the transfer completes in that cycle.
  - The winner's word is latched into eng_data_in and the winner is latched into rsp_id.
  - Pointer becomes winner+1, wrapping NREQ-1 -> 0. Next state is ARM.
- ARM: one cycle, eng_set=1, eng_data_in held. Next state is RUN.
- RUN: eng_set=0, eng_data_in held stable. The timeout counter increments each cycle.
  - When eng_status=1: eng_data_out is captured into rsp_data, rsp_err=0, next state is RESP.
  - Nominal engine latency: status is seen on the 2nd RUN cycle. Request acceptance to rsp_valid is 4 cycles.
  - If the counter reaches TIMEOUT-1 without status: rsp_data=0, rsp_err=1, next state is RESP.
  - If status and timeout occur in the same cycle, status wins.
- RESP: rsp_valid=1, and rsp_data/rsp_id/rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, eng_set=1, counter=0, next state is IDLE.
  - No new request is granted in the same cycle (minimum 5-cycle issue interval).
- req_valid may drop while not granted; there is no obligation to hold it. A requester must not change req_data in a cycle where req_valid=1 && req_ready=1.
- An asynchronous reset mid-operation aborts the operation immediately. No response is produced, and the engine is re-cleared via eng_set=1.
- Requests with req_valid while the FSM is not in IDLE are held pending, never dropped.
- Fairness: with all requesters continuously valid, each is served exactly once per NREQ grants.

Optional Feature:
PERM_WEIGHT_CHECK_EN:
- Defined: in RUN, on status, compare popcount(eng_data_out) with popcount(eng_data_in). A permutation preserves Hamming weight, so a mismatch sets rsp_err=1 while rsp_data still carries eng_data_out. A sticky output chk_fail (1 bit, reset 0) is added; it is cleared only by reset.
- Undefined: no popcount logic and no chk_fail port. rsp_err reflects timeout only.

Decomposition:
- Shared package perm_pkg holds:
  - WORD_W=64
  - FSM state encoding (IDLE=2'd0, ARM=2'd1, RUN=2'd2, RESP=2'd3)
  - default TIMEOUT
- Sub-module rr_arbiter (NREQ-wide round-robin: req, pointer -> one-hot grant, grant index, any) is natural and reusable.
- The popcount comparator stays inline under the macro.

Test Plan:
- Single request: req_valid=2'b01, req_data[63:0]=64'h8000_0000_0000_0000, paired with the real engine -> req_ready[0] pulses once. rsp_valid rises 4 cycles later with rsp_id=0, rsp_err=0, and rsp_data equal to the mapped single bit (golden model).
- Round-robin: both requesters continuously valid, 6 transactions -> rsp_id sequence 0,1,0,1,0,1. Each req_ready is one-hot and is never asserted outside IDLE.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_id stay stable, no req_ready, eng_set stays 0. Then rsp_ready=1 -> IDLE the next cycle.
- Timeout: engine stub that never raises status, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_data=0 after 16 RUN cycles. The next request completes normally.
- Reset mid-RUN: drop rst_n for 1 cycle while in RUN -> all outputs are at reset values immediately, eng_set=1, no response is emitted, and the pending request is re-served afterwards.
- With PERM_WEIGHT_CHECK_EN: engine stub returns 64'h0 for input 64'hFF -> rsp_err=1, chk_fail=1 (sticky). A correct engine gives rsp_err=0 for input 64'hFFFF_0000_0000_0001.

Source files
------------

// File: rtl/perm_pkg.sv
// ============================================================================
// Module   : perm_pkg
// Brief    : Shared word width, FSM encoding and default timeout for the
//            inverse-permutation engine controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package perm_pkg;

    localparam int WORD_W      = 64;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; the search starts at ptr and wraps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [NREQ-1:0] hi_req;

    // Lowest requester at or above ptr wins; otherwise the lowest overall.
    always_comb begin
        hi_req    = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = IDW'(i);
                any       = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                grant_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any && (grant_idx == IDW'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/perm_arbiter_ctrl.sv
// ============================================================================
// Module   : perm_arbiter_ctrl
// Brief    : Arbitrates NREQ requesters onto the shared inverse-permutation
//            engine. Optional macro PERM_WEIGHT_CHECK_EN adds a Hamming-weight
//            check on the engine result and a sticky chk_fail output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module perm_arbiter_ctrl
    import perm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IDW     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [WORD_W*NREQ-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WORD_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   eng_set,
    output logic [WORD_W-1:0]      eng_data_in,
    input  logic                   eng_status,
    input  logic [WORD_W-1:0]      eng_data_out,
`ifdef PERM_WEIGHT_CHECK_EN
    output logic                   chk_fail,
`endif
    output logic                   busy
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_t              state_q;
    state_t              state_d;
    logic [IDW-1:0]      ptr_q;
    logic [CNTW-1:0]     cnt_q;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_idx;
    logic                any;
    logic [WORD_W-1:0]   win_word;
    logic [IDW-1:0]      ptr_next;
    logic                timeout_hit;
    logic                weight_bad;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_word = req_data[WORD_W*i +: WORD_W];
            end
        end
    end

    assign ptr_next    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

`ifdef PERM_WEIGHT_CHECK_EN
    assign weight_bad = ($countones(eng_data_out) != $countones(eng_data_in));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_fail <= 1'b0;
        end else if (state_q == RUN && eng_status && weight_bad) begin
            chk_fail <= 1'b1;
        end
    end
`else
    assign weight_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        eng_set   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                eng_set = 1'b1;
                busy    = 1'b0;
                // The grant is combinational, so mask it while reset is held.
                if (rst_n) begin
                    req_ready = grant;
                end
                if (any) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                eng_set = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (eng_status || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            eng_data_in <= '0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        eng_data_in <= win_word;
                        rsp_id      <= grant_idx;
                        ptr_q       <= ptr_next;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    // Status takes priority over a coincident timeout.
                    if (eng_status) begin
                        rsp_data <= eng_data_out;
                        rsp_err  <= weight_bad;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_perm_arbiter_ctrl.sv
// ============================================================================
// Module   : tb_perm_arbiter_ctrl
// Brief    : Self-checking bench for perm_arbiter_ctrl with an engine model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_perm_arbiter_ctrl;

    localparam int NREQ     = 2;
    localparam int IDW      = 3;
    localparam int TO       = 16;
    localparam int EM_NORM  = 0;
    localparam int EM_STALL = 1;
    localparam int EM_ZERO  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [64*NREQ-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic              rsp_err;
    logic              eng_set;
    logic [63:0]       eng_data_in;
    logic              eng_status = 1'b0;
    logic [63:0]       eng_data_out = '0;
    logic              busy;
`ifdef PERM_WEIGHT_CHECK_EN
    logic              chk_fail;
`endif

    always #5 clk = ~clk;

    perm_arbiter_ctrl #(
        .NREQ    (NREQ),
        .TIMEOUT (TO),
        .IDW     (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .eng_set      (eng_set),
        .eng_data_in  (eng_data_in),
        .eng_status   (eng_status),
        .eng_data_out (eng_data_out),
`ifdef PERM_WEIGHT_CHECK_EN
        .chk_fail     (chk_fail),
`endif
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    int eng_mode = EM_NORM;

    // Golden inverse permutation: input bit i lands on bit (5*i+3) mod 64.
    function automatic logic [63:0] perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[(i * 5 + 3) % 64] = x[i];
        end
        return y;
    endfunction

    always @(posedge clk) begin
        if (eng_set) begin
            eng_status   <= 1'b0;
            eng_data_out <= '0;
        end else if (eng_mode == EM_NORM) begin
            eng_status   <= 1'b1;
            eng_data_out <= perm(eng_data_in);
        end else if (eng_mode == EM_ZERO) begin
            eng_status   <= 1'b1;
            eng_data_out <= '0;
        end else begin
            eng_status   <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        logic           err;
        int             acc_cyc;
        int             lat;
    } exp_t;

    exp_t           sbq[$];
    exp_t           mon_e;
    exp_t           mon_h;
    logic [63:0]    mon_w;
    logic [IDW-1:0] obs_ids[$];
    int             cyc = 0;
    int             acc_count = 0;
    int             rsp_count = 0;
    logic [IDW-1:0] last_id = '0;
    logic [63:0]    last_data = '0;
    logic           rsp_valid_d = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rsp_valid_d = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check("grant_onehot", 64'($onehot(req_ready)), 64'(1));
                check("grant_in_idle", 64'(busy), 64'(0));
                check("grant_valid", 64'(req_ready & ~req_valid), 64'(0));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_w         = req_data[64*i +: 64];
                    mon_e.id      = IDW'(i);
                    mon_e.acc_cyc = cyc;
                    mon_e.lat     = 4;
                    mon_e.err     = 1'b0;
                    if (eng_mode == EM_NORM) begin
                        mon_e.data = perm(mon_w);
                    end else if (eng_mode == EM_STALL) begin
                        mon_e.data = '0;
                        mon_e.err  = 1'b1;
                        mon_e.lat  = 2 + TO;
                    end else begin
                        mon_e.data = '0;
`ifdef PERM_WEIGHT_CHECK_EN
                        mon_e.err  = (mon_w != '0);
`endif
                    end
                    sbq.push_back(mon_e);
                    acc_count++;
                end
            end
            if (rsp_valid && !rsp_valid_d) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    check("latency", 64'(cyc - sbq[0].acc_cyc), 64'(sbq[0].lat));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected_hs", 64'(1), 64'(0));
                end else begin
                    mon_h = sbq.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(mon_h.id));
                    check("rsp_data", rsp_data, mon_h.data);
                    check("rsp_err", 64'(rsp_err), 64'(mon_h.err));
                end
                rsp_count++;
                last_id   = rsp_id;
                last_data = rsp_data;
                obs_ids.push_back(rsp_id);
            end
            rsp_valid_d = rsp_valid;
        end
    end

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_count < target) begin
            checks++;
            errors++;
            $display("FAIL wait_acc: accepted=%0d required=%0d", acc_count, target);
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_count < target) begin
            checks++;
            errors++;
            $display("FAIL wait_rsp: responses=%0d required=%0d", rsp_count, target);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_id, rsp_err, eng_set, busy}),
              64'({2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}));
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
        check({tag, "_eng_data_in"}, eng_data_in, 64'd0);
    endtask

    typedef struct {
        logic [1:0]     v;
        logic [63:0]    d0;
        logic [63:0]    d1;
        int             mode;
        logic [IDW-1:0] exp_id;
    } vec_t;

    task automatic run_vec(input vec_t tv);
        int a0;
        int r0;
        a0 = acc_count;
        r0 = rsp_count;
        eng_mode  = tv.mode;
        req_data  = {tv.d1, tv.d0};
        req_valid = tv.v;
        wait_acc(a0 + 1, 20);
        req_valid = '0;
        wait_rsp(r0 + 1, 60);
        check("vec_id", 64'(last_id), 64'(tv.exp_id));
    endtask

    vec_t           vt[9];
    int             a0;
    int             r0;
    int             n;
    logic [IDW-1:0] cap_id;
    logic [63:0]    cap_data;

    initial begin
        // Expected IDs follow the round-robin pointer from reset (pointer 0).
        vt[0] = '{2'b01, 64'h8000_0000_0000_0000, 64'h0,                    EM_NORM,  3'd0};
        vt[1] = '{2'b10, 64'h0,                    64'h0123_4567_89AB_CDEF, EM_NORM,  3'd1};
        vt[2] = '{2'b11, 64'hFFFF_0000_0000_0001, 64'hDEAD_BEEF_0000_0001, EM_NORM,  3'd0};
        vt[3] = '{2'b11, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, EM_NORM,  3'd1};
        vt[4] = '{2'b10, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFF, EM_NORM,  3'd1};
        vt[5] = '{2'b01, 64'hCAFE_F00D_0000_0003, 64'h0,                    EM_STALL, 3'd0};
        vt[6] = '{2'b01, 64'h0000_0001_0000_0001, 64'h0,                    EM_NORM,  3'd0};
        vt[7] = '{2'b11, 64'h0,                    64'h8421_8421_8421_8421, EM_NORM,  3'd1};
        vt[8] = '{2'b01, 64'h0000_0000_0000_00FF, 64'h0,                    EM_ZERO,  3'd0};

        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            run_vec(vt[v]);
            if (v == 0) begin
                check("single_bit", last_data, 64'h4000_0000_0000_0000);
            end
        end
`ifdef PERM_WEIGHT_CHECK_EN
        check("chk_fail_set", 64'(chk_fail), 64'(1));
`endif

        // Backpressure: response held while requester 1 waits.
        eng_mode  = EM_NORM;
        rsp_ready = 1'b0;
        req_data  = {64'hA5A5_0000_FFFF_1234, 64'h0F0F_0F0F_0F0F_0F0F};
        a0 = acc_count;
        r0 = rsp_count;
        req_valid = 2'b01;
        wait_acc(a0 + 1, 20);
        req_valid = 2'b10;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        cap_id   = rsp_id;
        cap_data = rsp_data;
        repeat (10) begin
            @(negedge clk);
            check("bp_data", rsp_data, cap_data);
            check("bp_ctrl", 64'({rsp_valid, rsp_id, req_ready, eng_set}),
                  64'({1'b1, cap_id, 2'b00, 1'b0}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle", 64'({busy, req_ready}), 64'({1'b0, 2'b10}));
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(r0 + 2, 60);
        check("bp_second_id", 64'(last_id), 64'(1));
`ifdef PERM_WEIGHT_CHECK_EN
        check("chk_fail_sticky", 64'(chk_fail), 64'(1));
`endif

        // Reset while in RUN: no response, request re-served afterwards.
        eng_mode = EM_NORM;
        req_data = {64'h0, 64'h00FF_00FF_1234_5678};
        a0 = acc_count;
        req_valid = 2'b01;
        wait_acc(a0 + 1, 20);
        @(posedge clk); #1;
        sbq.delete();
        r0 = rsp_count;
        rst_n = 1'b0;
        #1;
        check_reset("mid_run");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_run_no_rsp", 64'(rsp_count), 64'(r0));
        wait_acc(a0 + 2, 20);
        req_valid = '0;
        wait_rsp(r0 + 1, 60);
        check("mid_run_reserved_id", 64'(last_id), 64'(0));
`ifdef PERM_WEIGHT_CHECK_EN
        check("chk_fail_cleared", 64'(chk_fail), 64'(0));
`endif

        // Clean reset so the pointer restarts at 0, then round-robin.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs_ids.delete();
        eng_mode  = EM_NORM;
        req_data  = {64'h1357_9BDF_0246_8ACE, 64'h0000_0000_0000_00F0};
        a0 = acc_count;
        r0 = rsp_count;
        req_valid = 2'b11;
        wait_acc(a0 + 6, 60);
        req_valid = '0;
        wait_rsp(r0 + 6, 60);
        check("rr_count", 64'(obs_ids.size()), 64'(6));
        for (int k = 0; k < 6 && k < obs_ids.size(); k++) begin
            check("rr_id", 64'(obs_ids[k]), 64'(k % 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
